// File: rtl/alu_nbit_seq_if.sv
// Instruction/result bus for alu_nbit_seq: valid/ready instruction input,
// registered result words and flags with a one-cycle done pulse.
interface alu_nbit_seq_if #(parameter int WIDTH = 8);
  localparam int IW = 2*WIDTH + 3;

  logic [IW-1:0]    instruction;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] extended_out;
  logic             overflow;
  logic             carry;
  logic             done;

  modport master (
    output instruction, in_valid,
    input  in_ready, out, extended_out, overflow, carry, done
  );

  modport slave (
    input  instruction, in_valid,
    output in_ready, out, extended_out, overflow, carry, done
  );
endinterface

// File: rtl/alu_nbit_seq.sv
// Sequential WIDTH-bit ALU: single-cycle logic/arith ops, shift-add multiply
// and restoring divide iterating over WIDTH cycles; results held until next done.
//
//   state  | meaning
//   S_IDLE | ready for an instruction; single-cycle ops complete here
//   S_ITER | MUL/DIV partial step per cycle, counter 0..WIDTH-1
module alu_nbit_seq #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  alu_nbit_seq_if.slave  bus
);
  localparam int IW = 2*WIDTH + 3;
  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ITER = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic [WIDTH-1:0] out_q, ext_q;
  logic             ovf_q, cry_q, done_q;

  logic [2:0]       op_in;
  logic [WIDTH-1:0] a_in, b_in;
  logic             accept;

  assign op_in  = bus.instruction[IW-1:2*WIDTH];
  assign a_in   = bus.instruction[2*WIDTH-1:WIDTH];
  assign b_in   = bus.instruction[WIDTH-1:0];

  assign bus.in_ready     = (state == S_IDLE) && !reset;
  assign accept           = bus.in_valid && bus.in_ready;
  assign bus.out          = out_q;
  assign bus.extended_out = ext_q;
  assign bus.overflow     = ovf_q;
  assign bus.carry        = cry_q;
  assign bus.done         = done_q;

  // Single-cycle result, computed straight from the instruction word
  logic [WIDTH:0]     add_sum, sub_dif;
  logic [2*WIDTH-1:0] shl_val;
  logic [WIDTH-1:0]   res_lo, res_hi;
  logic               res_c, res_v;

  assign add_sum = {1'b0, a_in} + {1'b0, b_in};
  assign sub_dif = {1'b0, a_in} - {1'b0, b_in};
  assign shl_val = {{WIDTH{1'b0}}, a_in} << b_in[CW-1:0];

  always_comb begin
    res_lo = '0;
    res_hi = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    case (op_in)
      OP_ADD: begin
        res_lo = add_sum[WIDTH-1:0];
        res_c  = add_sum[WIDTH];
        res_v  = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (add_sum[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_SUB: begin
        res_lo = sub_dif[WIDTH-1:0];
        res_c  = sub_dif[WIDTH];
        res_v  = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (sub_dif[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_AND: res_lo = a_in & b_in;
      OP_XOR: res_lo = a_in ^ b_in;
      OP_OR:  res_lo = a_in | b_in;
      OP_SHL: begin
        res_lo = shl_val[WIDTH-1:0];
        res_hi = shl_val[2*WIDTH-1:WIDTH];
        res_c  = |shl_val[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  // Iterative step. MUL: hi accumulates, lo holds the multiplier shifting out
  // as product bits shift in. DIV: hi is the partial remainder, lo shifts the
  // dividend out and quotient bits in. B=0 naturally yields all-ones / A.
  logic [WIDTH:0]   m_sum, d_rs;
  logic             d_ge;
  logic [WIDTH-1:0] hi_nx, lo_nx;

  assign m_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign d_rs  = {hi_q, lo_q[WIDTH-1]};
  assign d_ge  = d_rs >= {1'b0, b_q};

  always_comb begin
    hi_nx = m_sum[WIDTH:1];
    lo_nx = {m_sum[0], lo_q[WIDTH-1:1]};
    if (is_div) begin
      hi_nx = d_ge ? (d_rs[WIDTH-1:0] - b_q) : d_rs[WIDTH-1:0];
      lo_nx = {lo_q[WIDTH-2:0], d_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      out_q  <= '0;
      ext_q  <= '0;
      ovf_q  <= 1'b0;
      cry_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_in == OP_MUL || op_in == OP_DIV) begin
              state  <= S_ITER;
              cnt    <= '0;
              is_div <= (op_in == OP_DIV);
              a_q    <= a_in;
              b_q    <= b_in;
              hi_q   <= '0;
              lo_q   <= (op_in == OP_DIV) ? a_in : b_in;
            end else begin
              out_q  <= res_lo;
              ext_q  <= res_hi;
              cry_q  <= res_c;
              ovf_q  <= res_v;
              done_q <= 1'b1;
            end
          end
        end
        S_ITER: begin
          hi_q <= hi_nx;
          lo_q <= lo_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            state  <= S_IDLE;
            out_q  <= lo_nx;
            ext_q  <= hi_nx;
            cry_q  <= 1'b0;
            ovf_q  <= is_div ? (b_q == '0) : (hi_nx != '0);
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
